// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one single-port synchronous RAM between two
// requesters (A and B) with round-robin arbitration, one access per cycle.
// After reset the RAM is optionally cleared to INIT_VAL before any request
// is accepted. Read data comes back the cycle after the accept, straight
// from the RAM's registered output.
module ram_access_arbiter #(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 4,
  parameter int                INIT_EN  = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  // requester A
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rdata,
  // requester B
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rdata,
  // RAM side
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_done
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam state_t RESET_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] init_cnt, init_cnt_nx;
  logic              last_b, last_b_nx;   // 1 = B holds the most recent grant
  logic              grant_a, grant_b;

  logic              ram_we_c, ram_re_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_din_c;

  // Response bookkeeping for the access accepted in the previous cycle.
  logic              a_pend, b_pend;
  logic              a_pend_rd, b_pend_rd;
  logic [DATA_W-1:0] a_hold, b_hold;
  logic [DATA_W-1:0] a_rsp_data, b_rsp_data;

  assign a_rsp_data = a_pend_rd ? ram_dout : '0;
  assign b_rsp_data = b_pend_rd ? ram_dout : '0;

  // State register, clear counter, grant history and response pipeline.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers
    // update from the same pre-edge values, independent of statement order.
    if (rst) begin
      state     <= RESET_STATE;
      init_cnt  <= '0;
      last_b    <= 1'b1;
      a_pend    <= 1'b0;
      b_pend    <= 1'b0;
      a_pend_rd <= 1'b0;
      b_pend_rd <= 1'b0;
      a_hold    <= '0;
      b_hold    <= '0;
    end else begin
      state     <= state_nx;
      init_cnt  <= init_cnt_nx;
      last_b    <= last_b_nx;
      a_pend    <= grant_a;
      b_pend    <= grant_b;
      a_pend_rd <= grant_a & ~a_we;
      b_pend_rd <= grant_b & ~b_we;
      if (a_pend) a_hold <= a_rsp_data;
      if (b_pend) b_hold <= b_rsp_data;
    end
  end

  // Next-state, round-robin grant and RAM command selection.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_nx    = state;
    init_cnt_nx = init_cnt;
    last_b_nx   = last_b;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_addr_c  = '0;
    ram_din_c   = '0;
    case (state)
      S_INIT: begin
        ram_we_c    = 1'b1;
        ram_addr_c  = init_cnt;
        ram_din_c   = INIT_VAL;
        init_cnt_nx = init_cnt + ADDR_W'(1);
        if (init_cnt == '1) state_nx = S_RUN;
      end
      S_RUN: begin
        // A wins unless B is also asking and A was served last.
        grant_a = a_valid & (~b_valid | last_b);
        grant_b = b_valid & ~grant_a;
        if (grant_a) begin
          ram_we_c   = a_we;
          ram_re_c   = ~a_we;
          ram_addr_c = a_addr;
          ram_din_c  = a_wdata;
          last_b_nx  = 1'b0;
        end else if (grant_b) begin
          ram_we_c   = b_we;
          ram_re_c   = ~b_we;
          ram_addr_c = b_addr;
          ram_din_c  = b_wdata;
          last_b_nx  = 1'b1;
        end
      end
      default: state_nx = RESET_STATE;
    endcase
  end

  // Reset forces every output low in the same cycle, including a response
  // that was already registered when reset arrived.
  assign a_ready     = ~rst & grant_a;
  assign b_ready     = ~rst & grant_b;
  assign ram_we      = ~rst & ram_we_c;
  assign ram_re      = ~rst & ram_re_c;
  assign ram_addr    = rst ? '0 : ram_addr_c;
  assign ram_din     = rst ? '0 : ram_din_c;
  assign a_rsp_valid = ~rst & a_pend;
  assign b_rsp_valid = ~rst & b_pend;
  assign a_rdata     = rst ? '0 : (a_pend ? a_rsp_data : a_hold);
  assign b_rdata     = rst ? '0 : (b_pend ? b_rsp_data : b_hold);
  assign init_done   = ~rst & (state == S_RUN);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Testbench for ram_access_arbiter: two instances (clear enabled / disabled),
// each attached to a behavioural 16x4 RAM. A cycle-level reference model
// derived from the arbitration rules is compared against every output on
// every cycle; directed sequences add literal expectations, then random
// traffic runs against the model.
module tb_ram_access_arbiter;

  localparam int N     = 2;   // 0: INIT_EN=1, 1: INIT_EN=0
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_valid[N], a_we[N], b_valid[N], b_we[N];
  logic [3:0] a_addr[N], a_wdata[N], b_addr[N], b_wdata[N];
  logic       a_ready[N], a_rsp_valid[N], b_ready[N], b_rsp_valid[N];
  logic [3:0] a_rdata[N], b_rdata[N];
  logic       ram_we[N], ram_re[N], init_done[N];
  logic [3:0] ram_addr[N], ram_din[N], ram_dout[N];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ram_access_arbiter #(.ADDR_W(4), .DATA_W(4), .INIT_EN(1), .INIT_VAL(4'h0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_we(a_we[0]), .a_addr(a_addr[0]),
    .a_wdata(a_wdata[0]), .a_rsp_valid(a_rsp_valid[0]), .a_rdata(a_rdata[0]),
    .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_we(b_we[0]), .b_addr(b_addr[0]),
    .b_wdata(b_wdata[0]), .b_rsp_valid(b_rsp_valid[0]), .b_rdata(b_rdata[0]),
    .ram_we(ram_we[0]), .ram_re(ram_re[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]),
    .ram_dout(ram_dout[0]), .init_done(init_done[0])
  );

  ram_access_arbiter #(.ADDR_W(4), .DATA_W(4), .INIT_EN(0), .INIT_VAL(4'h0)) dut_noinit (
    .clk(clk), .rst(rst),
    .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_we(a_we[1]), .a_addr(a_addr[1]),
    .a_wdata(a_wdata[1]), .a_rsp_valid(a_rsp_valid[1]), .a_rdata(a_rdata[1]),
    .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_we(b_we[1]), .b_addr(b_addr[1]),
    .b_wdata(b_wdata[1]), .b_rsp_valid(b_rsp_valid[1]), .b_rdata(b_rdata[1]),
    .ram_we(ram_we[1]), .ram_re(ram_re[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]),
    .ram_dout(ram_dout[1]), .init_done(init_done[1])
  );

  // Behavioural single-port RAMs with a registered read, preloaded with k^5.
  logic [3:0] mem[N][DEPTH];
  bit         ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < DEPTH; k++) mem[i][k] <= 4'(k ^ 5);
        ram_dout[i] <= '0;
      end
      ram_loaded <= 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ram_we[i]) mem[i][ram_addr[i]] <= ram_din[i];
        if (ram_re[i]) ram_dout[i] <= mem[i][ram_addr[i]];
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int         m_t[N];          // cycles since reset released
  bit         m_last_b[N];     // B was served most recently
  bit         m_pa[N], m_pb[N];
  logic [3:0] m_pa_d[N], m_pb_d[N], m_ha[N], m_hb[N];
  logic [3:0] m_sh[N][DEPTH];  // expected RAM contents
  bit         acc_a[N], acc_b[N];
  bit         model_loaded = 1'b0;

  task automatic model_cycle(input int i);
    bit         ga, gb, in_init, addr_care;
    bit         e_ra, e_rb, e_we, e_re, e_done, e_va, e_vb;
    logic [3:0] e_addr, e_din, e_da, e_db;
    string      p;
    p = $sformatf("i%0d ", i);
    ga = 0; gb = 0; in_init = 0; addr_care = 1;
    e_ra = 0; e_rb = 0; e_we = 0; e_re = 0; e_done = 0; e_va = 0; e_vb = 0;
    e_addr = '0; e_din = '0; e_da = '0; e_db = '0;
    if (!rst) begin
      in_init = (i == 0) && (m_t[i] < DEPTH);
      if (in_init) begin
        e_we = 1; e_addr = 4'(m_t[i]); e_din = 4'h0;
      end else begin
        e_done = 1;
        // The requester that was not served last goes first in the list.
        if (m_last_b[i]) begin ga = a_valid[i]; gb = b_valid[i] && !ga; end
        else             begin gb = b_valid[i]; ga = a_valid[i] && !gb; end
        addr_care = ga || gb;
        if (ga) begin e_we = a_we[i]; e_re = !a_we[i]; e_addr = a_addr[i]; e_din = a_wdata[i]; end
        if (gb) begin e_we = b_we[i]; e_re = !b_we[i]; e_addr = b_addr[i]; e_din = b_wdata[i]; end
      end
      e_ra = ga; e_rb = gb;
      e_va = m_pa[i]; e_da = m_pa[i] ? m_pa_d[i] : m_ha[i];
      e_vb = m_pb[i]; e_db = m_pb[i] ? m_pb_d[i] : m_hb[i];
    end
    check({p, "a_ready"}, a_ready[i], e_ra);
    check({p, "b_ready"}, b_ready[i], e_rb);
    check({p, "ram_we"}, ram_we[i], e_we);
    check({p, "ram_re"}, ram_re[i], e_re);
    if (addr_care) begin
      check({p, "ram_addr"}, ram_addr[i], e_addr);
      if (e_we || rst) check({p, "ram_din"}, ram_din[i], e_din);
    end
    check({p, "init_done"}, init_done[i], e_done);
    check({p, "a_rsp_valid"}, a_rsp_valid[i], e_va);
    check({p, "b_rsp_valid"}, b_rsp_valid[i], e_vb);
    check({p, "a_rdata"}, a_rdata[i], e_da);
    check({p, "b_rdata"}, b_rdata[i], e_db);

    // advance to the next cycle
    if (rst) begin
      m_t[i] = 0; m_last_b[i] = 1; m_pa[i] = 0; m_pb[i] = 0; m_ha[i] = '0; m_hb[i] = '0;
    end else begin
      if (m_pa[i]) m_ha[i] = m_pa_d[i];
      if (m_pb[i]) m_hb[i] = m_pb_d[i];
      m_pa[i] = ga; m_pb[i] = gb;
      m_pa_d[i] = (ga && !a_we[i]) ? m_sh[i][a_addr[i]] : 4'h0;
      m_pb_d[i] = (gb && !b_we[i]) ? m_sh[i][b_addr[i]] : 4'h0;
      if (in_init) m_sh[i][m_t[i]] = 4'h0;
      if (ga && a_we[i]) m_sh[i][a_addr[i]] = a_wdata[i];
      if (gb && b_we[i]) m_sh[i][b_addr[i]] = b_wdata[i];
      if (ga) m_last_b[i] = 0;
      if (gb) m_last_b[i] = 1;
      if (m_t[i] < 1000) m_t[i]++;
    end
    acc_a[i] = ga; acc_b[i] = gb;
  endtask

  // Single compare process: outputs are sampled mid-cycle.
  always @(negedge clk) begin
    if (!model_loaded) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < DEPTH; k++) m_sh[i][k] = 4'(k ^ 5);
      model_loaded = 1'b1;
    end
    for (int i = 0; i < N; i++) model_cycle(i);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // New request only after the previous one was accepted (or none pending).
  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (!a_valid[i] || acc_a[i]) begin
        a_valid[i] = ($urandom_range(0, 99) < 70);
        a_we[i]    = 1'($urandom_range(0, 1));
        a_addr[i]  = 4'($urandom_range(0, 15));
        a_wdata[i] = 4'($urandom_range(0, 15));
      end
      if (!b_valid[i] || acc_b[i]) begin
        b_valid[i] = ($urandom_range(0, 99) < 70);
        b_we[i]    = 1'($urandom_range(0, 1));
        b_addr[i]  = 4'($urandom_range(0, 15));
        b_wdata[i] = 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    bit ga_exp[9];
    bit gb_exp[9];
    for (int i = 0; i < N; i++) begin
      a_valid[i] = 0; a_we[i] = 0; a_addr[i] = '0; a_wdata[i] = '0;
      b_valid[i] = 0; b_we[i] = 0; b_addr[i] = '0; b_wdata[i] = '0;
    end
    rst = 1;
    repeat (3) tick();

    // Release reset; instance 1 (no clear) reads addr 7 immediately.
    a_valid[1] = 1; a_we[1] = 0; a_addr[1] = 4'd7;
    rst = 0;
    @(negedge clk);
    check("noinit init_done at cycle 0", init_done[1], 1);
    check("noinit a_ready at cycle 0", a_ready[1], 1);
    check("clear addr 0", ram_addr[0], 0);
    check("clear we at cycle 0", ram_we[0], 1);
    tick();
    a_valid[1] = 0;
    @(negedge clk);
    check("noinit rsp_valid", a_rsp_valid[1], 1);
    check("noinit rdata addr 7", a_rdata[1], 4'h2);
    check("clear addr 1", ram_addr[0], 1);
    for (int k = 2; k < DEPTH; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("clear addr %0d", k), ram_addr[0], k);
      check("init_done low during clear", init_done[0], 0);
    end
    tick();
    @(negedge clk);
    check("init_done at cycle 16", init_done[0], 1);
    check("no RAM write after clear", ram_we[0], 0);

    // Write 0xA to addr 3, then read it back.
    tick();
    a_valid[0] = 1; a_we[0] = 1; a_addr[0] = 4'd3; a_wdata[0] = 4'hA;
    @(negedge clk);
    check("write accept", a_ready[0], 1);
    check("write din", ram_din[0], 4'hA);
    tick();
    a_we[0] = 0;
    @(negedge clk);
    check("write rsp_valid", a_rsp_valid[0], 1);
    check("write rsp rdata", a_rdata[0], 0);
    check("read accept", ram_re[0], 1);
    tick();
    a_valid[0] = 0;
    @(negedge clk);
    check("read rsp_valid", a_rsp_valid[0], 1);
    check("read-after-write rdata", a_rdata[0], 4'hA);
    tick();
    @(negedge clk);
    check("rsp_valid one pulse", a_rsp_valid[0], 0);
    check("rdata holds", a_rdata[0], 4'hA);

    // B alone for 3 cycles, then A joins: B,B,B,A,B,A,B,A,B.
    for (int c = 0; c < 9; c++) begin
      ga_exp[c] = (c >= 3) && (((c - 3) % 2) == 0);
      gb_exp[c] = !ga_exp[c];
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      a_valid[0] = (c >= 3) && (c < 9); a_we[0] = 0; a_addr[0] = 4'd3;
      b_valid[0] = (c < 9);             b_we[0] = 0; b_addr[0] = 4'd5;
      @(negedge clk);
      if (c < 9) begin
        check($sformatf("rr a_ready c%0d", c), a_ready[0], ga_exp[c]);
        check($sformatf("rr b_ready c%0d", c), b_ready[0], gb_exp[c]);
      end
      if (c > 0) begin
        check($sformatf("rr a_rsp c%0d", c), a_rsp_valid[0], ga_exp[c-1]);
        check($sformatf("rr b_rsp c%0d", c), b_rsp_valid[0], gb_exp[c-1]);
        if (ga_exp[c-1]) check("rr a_rdata", a_rdata[0], 4'hA);
        if (gb_exp[c-1]) check("rr b_rdata", b_rdata[0], 4'h0);
      end
    end

    // Reset lands the cycle after a read accept: the response is dropped.
    tick();
    a_valid[0] = 1; a_we[0] = 0; a_addr[0] = 4'd3; b_valid[0] = 0;
    @(negedge clk);
    check("pre-reset accept", a_ready[0], 1);
    tick();
    rst = 1; a_valid[0] = 0;
    @(negedge clk);
    check("rsp dropped by reset", a_rsp_valid[0], 0);
    check("rdata zero in reset", a_rdata[0], 0);
    check("init_done zero in reset", init_done[0], 0);
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    check("clear restarts at 0", ram_addr[0], 0);
    check("clear restarts we", ram_we[0], 1);

    // Random traffic on both instances.
    repeat (600) begin
      tick();
      rand_drive();
    end
    tick();
    for (int i = 0; i < N; i++) begin a_valid[i] = 0; b_valid[i] = 0; end
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
